eight_queens_checker: RTL and testbench

- Read-side counterpart to the eight-queens solver: accepts a completed board (one queen column per row, rows streamed in order) and independently verifies it.
- Flags the first conflicting row and the kind of conflict.
- Sits downstream of the solver, or on a testbench or host port, as a sign-off checker for produced placements.
- Owns its own column and diagonal occupancy masks. It shares no state with the solver datapath.

---
 rtl/eight_queens_checker.sv | 143 ++++++++++++++
 tb/tb_eight_queens_checker.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/eight_queens_checker.sv
// rtl/eight_queens_checker.sv - streams one queen column per row and reports the first conflict
module eight_queens_checker #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_col,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [W-1:0] fail_row,
  output logic [1:0]   conflict_type
);

  localparam int M = 2 * N - 1;
  localparam logic [W:0]   N_EXT    = (W + 1)'(N);
  localparam logic [W:0]   NM1_EXT  = (W + 1)'(N - 1);
  localparam logic [W-1:0] LAST_ROW = W'(N - 1);

  typedef enum logic [1:0] {IDLE, ACCEPT, REPORT} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] row_q, row_d;
  logic [N-1:0] col_used_q, col_used_d;
  logic [M-1:0] sum_used_q, sum_used_d;
  logic [M-1:0] diff_used_q, diff_used_d;
  logic         fail_seen_q, fail_seen_d;
  logic         in_ready_q, in_ready_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         pass_q, pass_d;
  logic [W-1:0] fail_row_q, fail_row_d;
  logic [1:0]   conflict_type_q, conflict_type_d;

  logic         hs;
  logic         in_range;
  logic         col_hit, sum_hit, diff_hit, any_hit;
  logic [W:0]   sum_idx, diff_idx;

  assign hs       = in_valid & in_ready_q & (state_q == ACCEPT);
  assign sum_idx  = {1'b0, row_q} + {1'b0, in_col};
  // Offset by N-1 so the difference diagonal index never goes negative.
  assign diff_idx = {1'b0, row_q} + NM1_EXT - {1'b0, in_col};
  assign in_range = ({1'b0, in_col} < N_EXT);
  assign col_hit  = !in_range || col_used_q[in_col];
  assign sum_hit  = in_range && sum_used_q[sum_idx];
  assign diff_hit = in_range && diff_used_q[diff_idx];
  assign any_hit  = col_hit | sum_hit | diff_hit;

  always_comb begin
    state_d         = state_q;
    row_d           = row_q;
    col_used_d      = col_used_q;
    sum_used_d      = sum_used_q;
    diff_used_d     = diff_used_q;
    fail_seen_d     = fail_seen_q;
    pass_d          = pass_q;
    fail_row_d      = fail_row_q;
    conflict_type_d = conflict_type_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d         = ACCEPT;
          row_d           = '0;
          col_used_d      = '0;
          sum_used_d      = '0;
          diff_used_d     = '0;
          fail_seen_d     = 1'b0;
          pass_d          = 1'b0;
          fail_row_d      = '0;
          conflict_type_d = 2'b00;
        end
      end
      ACCEPT: begin
        if (hs) begin
          if (!fail_seen_q && any_hit) begin
            fail_seen_d     = 1'b1;
            fail_row_d      = row_q;
            conflict_type_d = col_hit ? 2'b01 : (sum_hit ? 2'b10 : 2'b11);
          end
          if (in_range) begin
            col_used_d[in_col]    = 1'b1;
            sum_used_d[sum_idx]   = 1'b1;
            diff_used_d[diff_idx] = 1'b1;
          end
          row_d = row_q + W'(1);
          if (row_q == LAST_ROW) begin
            state_d = REPORT;
            pass_d  = !(fail_seen_q || any_hit);
          end
        end
      end
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Handshake-facing outputs follow the next state so they are registered yet cycle-accurate.
    in_ready_d = (state_d == ACCEPT);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == REPORT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      row_q           <= '0;
      col_used_q      <= '0;
      sum_used_q      <= '0;
      diff_used_q     <= '0;
      fail_seen_q     <= 1'b0;
      in_ready_q      <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      fail_row_q      <= '0;
      conflict_type_q <= 2'b00;
    end else begin
      state_q         <= state_d;
      row_q           <= row_d;
      col_used_q      <= col_used_d;
      sum_used_q      <= sum_used_d;
      diff_used_q     <= diff_used_d;
      fail_seen_q     <= fail_seen_d;
      in_ready_q      <= in_ready_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      pass_q          <= pass_d;
      fail_row_q      <= fail_row_d;
      conflict_type_q <= conflict_type_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign fail_row      = fail_row_q;
  assign conflict_type = conflict_type_q;

endmodule

// File: tb/tb_eight_queens_checker.sv
// tb/tb_eight_queens_checker.sv - directed self-checking bench for eight_queens_checker
module tb_eight_queens_checker;

  typedef logic [2:0] board_t [8];

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_col = 3'd0;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] fail_row;
  logic [1:0] conflict_type;

  int vectors = 0;
  int errors  = 0;

  eight_queens_checker #(.N(8), .W(3)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_col(in_col), .busy(busy), .done(done),
    .pass(pass), .fail_row(fail_row), .conflict_type(conflict_type)
  );

  always #5 clk = ~clk;

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Streams rows from a negedge; returns at the negedge right after the last handshake.
  task automatic stream(input board_t cols, input int nrows, input bit gaps, input bit mid_start);
    for (int r = 0; r < nrows; r++) begin
      if (gaps) begin
        for (int g = 0; g < (r % 3) + 1; g++) begin
          in_valid = 1'b0;
          start = (mid_start && r == 4 && g == 0);
          @(negedge clk);
          start = 1'b0;
        end
      end
      vectors++;
      if (in_ready !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL accept_row%0d: in_ready=%b done=%b, need in_ready=1 done=0", r, in_ready, done);
      end
      in_valid = 1'b1;
      in_col = cols[r];
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic check_verdict(input string name, input logic exp_pass, input logic [2:0] exp_row,
                               input logic [1:0] exp_type);
    vectors++;
    if (done !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0 || pass !== exp_pass ||
        fail_row !== exp_row || conflict_type !== exp_type) begin
      errors++;
      $display("FAIL %s_verdict: done=%b busy=%b rdy=%b pass=%b row=%0d type=%b, need 1 1 0 %b %0d %b",
               name, done, busy, in_ready, pass, fail_row, conflict_type, exp_pass, exp_row, exp_type);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || pass !== exp_pass || fail_row !== exp_row ||
        conflict_type !== exp_type) begin
      errors++;
      $display("FAIL %s_hold: done=%b busy=%b pass=%b row=%0d type=%b, need 0 0 %b %0d %b",
               name, done, busy, pass, fail_row, conflict_type, exp_pass, exp_row, exp_type);
    end
  endtask

  task automatic run_board(input string name, input board_t cols, input bit gaps, input bit mid_start,
                           input logic exp_pass, input logic [2:0] exp_row, input logic [1:0] exp_type);
    pulse_start();
    stream(cols, 8, gaps, mid_start);
    check_verdict(name, exp_pass, exp_row, exp_type);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 ||
        fail_row !== 3'd0 || conflict_type !== 2'b00) begin
      errors++;
      $display("FAIL reset_state: rdy=%b busy=%b done=%b pass=%b row=%0d type=%b, need all 0",
               in_ready, busy, done, pass, fail_row, conflict_type);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_legal();
    board_t b = '{3'd0, 3'd4, 3'd7, 3'd5, 3'd2, 3'd6, 3'd1, 3'd3};
    run_board("legal", b, 1'b0, 1'b0, 1'b1, 3'd0, 2'b00);
  endtask

  task automatic test_idle_ignores_valid();
    in_valid = 1'b1;
    in_col = 3'd2;
    repeat (2) @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b1) begin
      errors++;
      $display("FAIL idle_valid: rdy=%b busy=%b done=%b pass=%b, need 0 0 0 1", in_ready, busy, done, pass);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_column();
    board_t b = '{3'd0, 3'd4, 3'd7, 3'd5, 3'd2, 3'd6, 3'd1, 3'd0};
    run_board("column", b, 1'b0, 1'b0, 1'b0, 3'd7, 2'b01);
  endtask

  task automatic test_diff_diag();
    board_t b = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    run_board("diff", b, 1'b0, 1'b0, 1'b0, 3'd1, 2'b11);
  endtask

  task automatic test_sum_diag();
    board_t b = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    run_board("sum", b, 1'b0, 1'b0, 1'b0, 3'd1, 2'b10);
  endtask

  task automatic test_back_to_back_gaps();
    board_t b = '{3'd0, 3'd4, 3'd7, 3'd5, 3'd2, 3'd6, 3'd1, 3'd3};
    run_board("gaps", b, 1'b1, 1'b1, 1'b1, 3'd0, 2'b00);
  endtask

  task automatic test_reset_mid();
    board_t b = '{3'd0, 3'd4, 3'd7, 3'd5, 3'd2, 3'd6, 3'd1, 3'd3};
    pulse_start();
    stream(b, 4, 1'b0, 1'b0);
    vectors++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy: busy=%b rdy=%b, need 1 1", busy, in_ready);
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || pass !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: rdy=%b busy=%b pass=%b done=%b, need all 0", in_ready, busy, pass, done);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_board("after_reset", b, 1'b0, 1'b0, 1'b1, 3'd0, 2'b00);
  endtask

  initial begin
    test_reset();
    test_legal();
    test_idle_ignores_valid();
    test_column();
    test_diff_diag();
    test_sum_diag();
    test_back_to_back_gaps();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
